// File: rtl/rv32_pipeline_pkg.sv
// Shared definitions for the RV32IM pipeline: NOP encoding, reset vector,
// fetch-stage state encoding and the major opcodes decoded by control_unit.
package rv32_pipeline_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/fetch_unit_if.sv
// Signals between the fetch stage and its surroundings (hazard unit, EX
// redirect, instruction memory, IF/ID consumers). STATE_DBG exposes the FSM.
//
// Handshake: the memory transfers a word in any cycle where IMEM_READ=1 and
// IMEM_BUSYWAIT=0 ("accept"); while IMEM_BUSYWAIT=1 the fetch side keeps
// IMEM_ADDR and IMEM_READ stable.
interface fetch_unit_if;
    import rv32_pipeline_pkg::*;

    logic         STALL;
    logic         BRANCH_TAKEN;
    logic [31:0]  BRANCH_TARGET;
    logic [31:0]  IMEM_ADDR;
    logic         IMEM_READ;
    logic [31:0]  IMEM_READDATA;
    logic         IMEM_BUSYWAIT;
    logic [31:0]  INSTRUCTION;
    logic [31:0]  PC_OUT;
    logic [31:0]  PC_PLUS4;
    logic         VALID;
    fetch_state_e STATE_DBG;

    modport master (
        input  STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
        output IMEM_ADDR, IMEM_READ, INSTRUCTION, PC_OUT, PC_PLUS4, VALID, STATE_DBG
    );

    modport slave (
        output STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
        input  IMEM_ADDR, IMEM_READ, INSTRUCTION, PC_OUT, PC_PLUS4, VALID, STATE_DBG
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush wins over load and inserts a bubble
// (NOP, VALID=0) while the PC fields keep their last values.
module if_id_reg
    import rv32_pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_i + 32'd4;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, a one-entry skid buffer for words
// returned during a stall, and the redirect/drain logic for EX branches.
module fetch_unit
    import rv32_pipeline_pkg::*;
(
    input  logic   CLK,
    input  logic   RESET,
    fetch_unit_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_word_q, buf_word_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  tgt_q, tgt_d;

    logic         imem_read;
    logic         accept;
    logic [31:0]  branch_tgt;
    logic         ifid_load;
    logic         ifid_flush;
    logic [31:0]  ld_word;
    logic [31:0]  ld_pc;

    // Read request depends only on state and reset, never on the other inputs.
    assign imem_read  = RESET && (state_q != ST_HOLD);
    assign accept     = imem_read && !bus.IMEM_BUSYWAIT;
    assign branch_tgt = bus.BRANCH_TARGET & ~32'h3;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_word_d = buf_word_q;
        buf_pc_d   = buf_pc_q;
        tgt_d      = tgt_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ld_word    = bus.IMEM_READDATA;
        ld_pc      = pc_q;
        if (bus.BRANCH_TAKEN) begin
            // Redirect beats stall; an in-flight access must finish first.
            ifid_flush = 1'b1;
            if (state_q == ST_HOLD || accept) begin
                pc_d    = branch_tgt;
                state_d = ST_FETCH;
            end else begin
                tgt_d   = branch_tgt;
                state_d = ST_DRAIN;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (accept) begin
                        pc_d = pc_q + 32'd4;
                        if (bus.STALL) begin
                            buf_word_d = bus.IMEM_READDATA;
                            buf_pc_d   = pc_q;
                            state_d    = ST_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!bus.STALL) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!bus.STALL) begin
                        ld_word   = buf_word_q;
                        ld_pc     = buf_pc_q;
                        ifid_load = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    ifid_flush = 1'b1;
                    if (accept) begin
                        pc_d    = tgt_q;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_VECTOR;
            buf_word_q <= NOP_INSTR;
            buf_pc_q   <= 32'h0;
            tgt_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_word_q <= buf_word_d;
            buf_pc_q   <= buf_pc_d;
            tgt_q      <= tgt_d;
        end
    end

    if_id_reg u_if_id (
        .clk        (CLK),
        .rst_n      (RESET),
        .load       (ifid_load),
        .flush      (ifid_flush),
        .instr_i    (ld_word),
        .pc_i       (ld_pc),
        .instr_o    (bus.INSTRUCTION),
        .pc_o       (bus.PC_OUT),
        .pc_plus4_o (bus.PC_PLUS4),
        .valid_o    (bus.VALID)
    );

    assign bus.IMEM_ADDR = pc_q;
    assign bus.IMEM_READ = imem_read;
    assign bus.STATE_DBG = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: address-tagged zero-wait memory with
// injected wait states, stalls, redirects, drain, PC wrap and async reset.
module tb_fetch_unit;
    import rv32_pipeline_pkg::*;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_pass;

    fetch_unit_if bus ();

    fetch_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model: each word is tagged by its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign bus.IMEM_READDATA = mem_word(bus.IMEM_ADDR);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc, input logic valid);
        check_eq({tag, ".instr"}, bus.INSTRUCTION, instr);
        check_eq({tag, ".pc"}, bus.PC_OUT, pc);
        check_eq({tag, ".pc4"}, bus.PC_PLUS4, pc + 32'd4);
        check_eq({tag, ".valid"}, 32'(bus.VALID), 32'(valid));
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr, input logic rd);
        check_eq({tag, ".addr"}, bus.IMEM_ADDR, addr);
        check_eq({tag, ".read"}, 32'(bus.IMEM_READ), 32'(rd));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".instr"}, bus.INSTRUCTION, NOP_INSTR);
        check_eq({tag, ".valid"}, 32'(bus.VALID), 32'd0);
        check_eq({tag, ".pc"}, bus.PC_OUT, 32'h0);
        check_eq({tag, ".pc4"}, bus.PC_PLUS4, 32'h0);
        check_eq({tag, ".read"}, 32'(bus.IMEM_READ), 32'd0);
        check_eq({tag, ".st"}, 32'(bus.STATE_DBG), 32'(ST_FETCH));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.STALL         = 1'b0;
        bus.BRANCH_TAKEN  = 1'b0;
        bus.BRANCH_TARGET = 32'h0;
        bus.IMEM_BUSYWAIT = 1'b0;
        RESET = 1'b1;
        #2 RESET = 1'b0;
        #1 check_reset_vals("rst");

        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1 check_req("rel", 32'h0, 1'b1);

        // Zero-wait streaming
        tick(); check_ifid("s0", mem_word(32'h0), 32'h0, 1'b1); check_req("s0", 32'h4, 1'b1);
        tick(); check_ifid("s4", mem_word(32'h4), 32'h4, 1'b1); check_req("s4", 32'h8, 1'b1);

        // Three wait states on 0x8
        bus.IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ifid("bw", NOP_INSTR, 32'h4, 1'b0);
            check_req("bw", 32'h8, 1'b1);
        end
        bus.IMEM_BUSYWAIT = 1'b0;
        tick(); check_ifid("w8", mem_word(32'h8), 32'h8, 1'b1); check_req("w8", 32'hC, 1'b1);

        // Stall while word@0xC is accepted: skid into buffer
        bus.STALL = 1'b1;
        tick(); check_ifid("h1", mem_word(32'h8), 32'h8, 1'b1); check_req("h1", 32'h10, 1'b0);
        check_eq("h1.st", 32'(bus.STATE_DBG), 32'(ST_HOLD));
        tick(); check_ifid("h2", mem_word(32'h8), 32'h8, 1'b1); check_req("h2", 32'h10, 1'b0);
        bus.STALL = 1'b0;
        tick(); check_ifid("wC", mem_word(32'hC), 32'hC, 1'b1); check_req("wC", 32'h10, 1'b1);

        // Branch to 0x103 with simultaneous stall
        bus.BRANCH_TAKEN  = 1'b1;
        bus.BRANCH_TARGET = 32'h103;
        bus.STALL         = 1'b1;
        tick(); check_ifid("br1", NOP_INSTR, 32'hC, 1'b0); check_req("br1", 32'h100, 1'b1);
        bus.BRANCH_TAKEN = 1'b0;
        bus.STALL        = 1'b0;
        tick(); check_ifid("w100", mem_word(32'h100), 32'h100, 1'b1); check_req("w100", 32'h104, 1'b1);

        // Branch during busywait, re-branch in drain
        bus.IMEM_BUSYWAIT = 1'b1;
        bus.BRANCH_TAKEN  = 1'b1;
        bus.BRANCH_TARGET = 32'h200;
        tick(); check_ifid("d1", NOP_INSTR, 32'h100, 1'b0); check_req("d1", 32'h104, 1'b1);
        check_eq("d1.st", 32'(bus.STATE_DBG), 32'(ST_DRAIN));
        bus.BRANCH_TARGET = 32'h300;
        tick(); check_ifid("d2", NOP_INSTR, 32'h100, 1'b0); check_req("d2", 32'h104, 1'b1);
        bus.BRANCH_TAKEN  = 1'b0;
        bus.IMEM_BUSYWAIT = 1'b0;
        tick(); check_ifid("d3", NOP_INSTR, 32'h100, 1'b0); check_req("d3", 32'h300, 1'b1);
        check_eq("d3.st", 32'(bus.STATE_DBG), 32'(ST_FETCH));
        tick(); check_ifid("w300", mem_word(32'h300), 32'h300, 1'b1); check_req("w300", 32'h304, 1'b1);

        // Redirect to top of address space (low bits masked), then wrap
        bus.BRANCH_TAKEN  = 1'b1;
        bus.BRANCH_TARGET = 32'hFFFF_FFFE;
        tick(); check_ifid("br2", NOP_INSTR, 32'h300, 1'b0); check_req("br2", 32'hFFFF_FFFC, 1'b1);
        bus.BRANCH_TAKEN = 1'b0;
        tick();
        check_eq("wrap.instr", bus.INSTRUCTION, mem_word(32'hFFFF_FFFC));
        check_eq("wrap.pc", bus.PC_OUT, 32'hFFFF_FFFC);
        check_eq("wrap.pc4", bus.PC_PLUS4, 32'h0);
        check_req("wrap", 32'h0, 1'b1);

        // Async reset in the middle of a drain
        bus.IMEM_BUSYWAIT = 1'b1;
        bus.BRANCH_TAKEN  = 1'b1;
        bus.BRANCH_TARGET = 32'h400;
        tick(); check_eq("d4.st", 32'(bus.STATE_DBG), 32'(ST_DRAIN));
        #3 RESET = 1'b0;
        #1 check_reset_vals("rst2");
        bus.IMEM_BUSYWAIT = 1'b0;
        bus.BRANCH_TAKEN  = 1'b0;
        #2 RESET = 1'b1;
        #1 check_req("rel2", 32'h0, 1'b1);
        tick(); check_ifid("r0", mem_word(32'h0), 32'h0, 1'b1); check_req("r0", 32'h4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32IM pipeline. Owns the program counter, issues word reads to the instruction memory/cache, and drives the IF/ID pipeline register whose INSTRUCTION output feeds the `control_unit` in ID. It absorbs memory wait states, hazard stalls via a one-entry skid buffer, and branch/jump redirects from EX with flush.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value after reset
- CLK  input  1  pipeline clock, all state on rising edge
- RESET  input  1  asynchronous, active-low reset
- STALL  input  1  hazard unit: hold IF/ID and do not advance PC
- BRANCH_TAKEN  input  1  EX redirect (taken branch, JAL, JALR)
- BRANCH_TARGET  input  32  redirect address, bits [1:0] forced to 0 internally
- IMEM_ADDR  output  32  word address of current request
- IMEM_READ  output  1  read request
- IMEM_READDATA  input  32  instruction word, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
- IMEM_BUSYWAIT  input  1  memory busy; IMEM_ADDR must stay stable while high
- INSTRUCTION  output  32  IF/ID instruction to ID/control_unit
- PC_OUT  output  32  IF/ID PC of INSTRUCTION
- PC_PLUS4  output  32  IF/ID PC_OUT+4 (link value for JAL/JALR)
- VALID  output  1  IF/ID holds a real instruction

## Operation
- States: FETCH, HOLD, DRAIN. Registers: PC, buffer {word, pc}, saved target.
- "Accept" = IMEM_READ=1 and IMEM_BUSYWAIT=0 in a cycle; IMEM_ADDR=PC in FETCH and DRAIN, IMEM_READ=1 in FETCH/DRAIN, 0 in HOLD.
- FETCH, no branch:
  - accept, STALL=0: IF/ID <= {word, PC, PC+4, VALID=1}; PC <= PC+4.
  - accept, STALL=1: buffer <= {word, PC}; PC <= PC+4; IF/ID holds; -> HOLD.
  - no accept, STALL=0: IF/ID <= bubble (INSTRUCTION=NOP 32'h0000_0013, VALID=0, PC_OUT/PC_PLUS4 hold).
  - no accept, STALL=1: IF/ID holds.
- HOLD, no branch: STALL=1 stay; STALL=0 IF/ID <= buffer (VALID=1), -> FETCH.
- BRANCH_TAKEN (priority over STALL, any state): IF/ID <= bubble; buffer discarded.
  - FETCH with accept, or HOLD: returned/buffered word discarded; PC <= target; -> FETCH.
  - FETCH with BUSYWAIT=1: saved target <= target; -> DRAIN (address held).
  - DRAIN: saved target overwritten by newest target.
- DRAIN: on accept, word discarded, PC <= saved target, -> FETCH; IF/ID stays bubble.
- PC arithmetic 32-bit modulo 2^32; PC 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (async assert): PC=RESET_VECTOR, state FETCH, INSTRUCTION=NOP, VALID=0, PC_OUT=0, PC_PLUS4=0, IMEM_READ=0 while RESET low; IMEM_READ=1, IMEM_ADDR=RESET_VECTOR first cycle after deassert.
- Reset mid-access: in-flight request abandoned; memory must tolerate address change.
- Fetch latency: word accepted in cycle N appears on INSTRUCTION after edge N (1 cycle). Zero-wait memory: one instruction per cycle.
- Redirect: BRANCH_TAKEN sampled cycle N; IMEM_ADDR=target in N+1 (or N+1 after drain completes); first target instruction VALID earliest N+2.
- STALL release from HOLD: buffered word on INSTRUCTION next edge; new request issued same cycle as transfer-to-FETCH edge+1.
- All outputs registered except IMEM_ADDR/IMEM_READ (decoded from state and PC registers, glitch-free wrt inputs).

## Structure
- Shared package `rv32_pipeline_pkg`: NOP constant 32'h0000_0013, fetch state enum, RESET_VECTOR default, opcode constants shared with control_unit.
- One sub-module: `if_id_reg` (load/hold/flush register for INSTRUCTION, PC_OUT, PC_PLUS4, VALID; flush loads NOP/VALID=0).
- PC, buffer, FSM in fetch_unit top.

## Test plan
- Reset, zero-wait memory returning addr-tagged words -> INSTRUCTION sequence from 0x0,0x4,0x8 one per cycle, VALID=1 from 2nd cycle after release.
- BUSYWAIT high 3 cycles on 0x8 -> IMEM_ADDR stays 0x8, 3 bubbles (VALID=0, INSTRUCTION=0x13), then word@0x8.
- STALL 2 cycles while word@0xC accepted -> IF/ID holds word@0x8, IMEM_READ=0 in HOLD, word@0xC appears on release, no word lost or duplicated.
- BRANCH_TAKEN target 0x103 with STALL=1 same cycle -> flush, next IMEM_ADDR=0x100, word@0x100 VALID two cycles later.
- Branch to 0x200 during BUSYWAIT, second branch to 0x300 in DRAIN -> address held until accept, returned word discarded, fetch resumes at 0x300.
- PC 0xFFFF_FFFC fetch -> next IMEM_ADDR 0x0; async RESET mid-DRAIN -> all outputs reset values immediately.
